// File: rtl/inst_fetch_ctrl_if.sv
// rtl/inst_fetch_ctrl_if.sv - instruction memory and decode-side signal bundle for the fetch controller
interface inst_fetch_ctrl_if;
  logic        request_o;
  logic [31:0] instAddr_o;
  logic [31:0] inst_i;
  logic        dataOk_i;
  logic        redirect_i;
  logic [31:0] redirectPc_i;
  logic        instValid_o;
  logic [31:0] inst_o;
  logic [31:0] instPc_o;
  logic        instReady_i;

  modport master (
    output request_o, instAddr_o, instValid_o, inst_o, instPc_o,
    input  inst_i, dataOk_i, redirect_i, redirectPc_i, instReady_i
  );

  modport slave (
    input  request_o, instAddr_o, instValid_o, inst_o, instPc_o,
    output inst_i, dataOk_i, redirect_i, redirectPc_i, instReady_i
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - one-outstanding instruction fetcher with prefetch FIFO and redirect flush
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               reset_n,
  inst_fetch_ctrl_if.master bus
);

  localparam int unsigned   AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic          issue, push, pop;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    issue    = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (bus.redirect_i) begin
      // A response still owed by memory must be swallowed in DROP.
      pc_d     = bus.redirectPc_i & ~32'h3;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (state_q == WAIT) state_d = bus.dataOk_i ? IDLE : DROP;
    end else begin
      pop = (count_q != '0) && bus.instReady_i;
      unique case (state_q)
        IDLE: issue = (count_q < DEPTH_C);
        WAIT: begin
          if (bus.dataOk_i) begin
            push  = 1'b1;
            // The slot for the new request is reserved up front; a concurrent pop is not credited.
            issue = ((count_q + 1'b1) < DEPTH_C);
            if (!issue) state_d = IDLE;
          end
        end
        DROP: if (bus.dataOk_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (issue) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd4;
        state_d  = WAIT;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC & ~32'h3;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= bus.inst_i;
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign bus.request_o   = reset_n & issue;
  assign bus.instAddr_o  = pc_q;
  assign bus.instValid_o = (count_q != '0);
  assign bus.inst_o      = bus.instValid_o ? fifo_inst_q[rd_ptr_q] : '0;
  assign bus.instPc_o    = bus.instValid_o ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch-side initiator for the instruction memory request/response interface.
- Issues one-word fetch requests and accepts the response, which memory returns exactly one cycle after the request is sampled.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Supports a branch/exception redirect that flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address used after reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, minimum 2.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- request_o  output  1  fetch request to memory; sampled by memory on posedge clk.
- instAddr_o  output  32  byte address of the request; bits [1:0] always 0.
- inst_i  input  32  returned instruction word.
- dataOk_i  input  1  response valid; inst_i is valid in this cycle.
- redirect_i  input  1  one-cycle flush and restart request.
- redirectPc_i  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- instValid_o  output  1  FIFO head valid.
- inst_o  output  32  FIFO head instruction.
- instPc_o  output  32  FIFO head PC.
- instReady_i  input  1  decode accepts the head.

Behaviour:
Reset:
- Reset is asynchronous, active-low on reset_n; clock is clk.
- pc = RESET_PC, state = IDLE, FIFO empty.
- instValid_o = 0; inst_o and instPc_o = 0.
- request_o is combinational and is forced to 0 while reset_n is low.

Registers:
- pc: address of the next request.
- reqPc: address of the in-flight request.
- state: IDLE, WAIT or DROP.
- FIFO: FIFO_DEPTH entries of {pc, inst}, with rd/wr pointers and a count.

Outstanding requests and issue:
- At most one request is outstanding.
- Issue condition: not redirect_i AND (state==IDLE AND count<FIFO_DEPTH, OR state==WAIT AND dataOk_i AND count+1<FIFO_DEPTH).
- A same-cycle pop is not credited.
- Issue cycle: request_o=1 and instAddr_o=pc; at the edge, reqPc<=pc, pc<=pc+4 (mod 2^32 wrap), state<=WAIT.
- instAddr_o = pc in all cycles.

FSM:
- IDLE: issue if allowed, else stay.
- WAIT with no dataOk_i: stay.
- WAIT with dataOk_i: push {reqPc, inst_i}. Stay WAIT if a new request is issued in the same cycle (back-to-back, one word per cycle sustained); otherwise go IDLE.
- DROP with dataOk_i: discard inst_i, go IDLE.
- DROP with no dataOk_i: stay.
- dataOk_i in IDLE is a protocol error: ignore it, no push.

Redirect (highest priority):
- Effects: FIFO cleared (count=0, pointers reset); pc<=redirectPc_i with [1:0] forced to 00; no issue and no pop that cycle.
- State update: WAIT without dataOk_i goes to DROP. WAIT with dataOk_i discards that data and goes to IDLE. IDLE stays IDLE. DROP stays DROP and only pc is updated.
- The first request at the new pc occurs in the cycle after the redirect, or after the DROP response has been discarded.

Output handshake:
- instValid_o = (count!=0).
- inst_o and instPc_o show the head entry whenever valid.
- A pop occurs on instValid_o && instReady_i.
- Simultaneous push and pop leaves count unchanged; the pointers of both advance.
- The FIFO cannot overflow, because the issue condition reserves the slot.
- Entries leave in strict issue order.

Test Plan:
- Reset release with instReady_i=1 and memory word[n]=0x1000_0000+n: request_o=1 in cycles 0,1,2,… with instAddr_o=0x0,0x4,0x8. instValid_o first high in cycle 2 with inst_o=0x1000_0000, instPc_o=0; then one instruction per cycle.
- instReady_i=0 from reset: exactly 4 requests (0x0–0xC), then request_o=0 and the FIFO holds 4 entries. Raise instReady_i: entries pop in order, and the next request is 0x10 in the cycle after the first pop frees a slot.
- redirect_i with redirectPc_i=0x40 while in WAIT with dataOk_i=0: instValid_o=0 next cycle; the following response is discarded (never visible on inst_o); the next request is instAddr_o=0x40; the first valid has instPc_o=0x40.
- redirect_i coincident with dataOk_i, redirectPc_i=0x43: that data is dropped; request_o=1 with instAddr_o=0x40 the next cycle.
- Redirect to 0xFFFF_FFFC: requests 0xFFFF_FFFC then 0x0000_0000; instPc_o sequence matches.
- reset_n pulsed low mid-stream with FIFO at 3 entries: request_o=0 and instValid_o=0 immediately; after release, fetch restarts at RESET_PC and no stale response is pushed.
